// File: rtl/bsg_chip_pod_wh_arbiter.sv
// Round-robin wormhole arbiter merging num_in_p input links onto one output link.
// Optional per-input packet counters are enabled by defining BSG_CHIP_POD_WH_ARBITER_STATS_EN.

`ifdef BSG_CHIP_POD_WH_ARBITER_STATS_EN
module bsg_chip_pod_wh_pkt_counter #(
   parameter int width_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               inc_i,
   output logic [width_p-1:0] count_o
);
   // saturating: holds at all-ones
   always_ff @(posedge clk_i) begin
      if (reset_i)
         count_o <= '0;
      else if (inc_i && (count_o != '1))
         count_o <= count_o + width_p'(1);
   end
endmodule
`endif

module bsg_chip_pod_wh_arbiter #(
   parameter int num_in_p     = 2,
   parameter int flit_width_p = 32,
   parameter int cord_width_p = 7,
   parameter int len_width_p  = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic [num_in_p-1:0]                    v_i,
   input  logic [num_in_p-1:0][flit_width_p-1:0]  data_i,
   output logic [num_in_p-1:0]                    ready_and_o,
   output logic                                   v_o,
   output logic [flit_width_p-1:0]                data_o,
   input  logic                                   ready_and_i,
   output logic [num_in_p-1:0]                    grant_o,
   output logic [num_in_p-1:0][15:0]              pkt_count_o
);
   localparam int ptr_w = $clog2(num_in_p);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e                 state_r;
   logic [ptr_w-1:0]       rr_ptr_r, lock_r, sel, next_ptr;
   logic [len_width_p-1:0] count_r, hdr_len;
   logic                   any_v, xfer;
   int                     idx;

   // first valid input scanning upward from rr_ptr, wrapping past the top
   always_comb begin
      sel   = '0;
      any_v = 1'b0;
      idx   = 0;
      for (int i = 0; i < num_in_p; i++) begin
         idx = int'(rr_ptr_r) + i;
         if (idx >= num_in_p) idx = idx - num_in_p;
         if (!any_v && v_i[idx]) begin
            any_v = 1'b1;
            sel   = ptr_w'(idx);
         end
      end
   end

   assign next_ptr = (sel == ptr_w'(num_in_p-1)) ? '0 : sel + ptr_w'(1);

   // selection is combinational so a stalled header can be preempted next cycle
   always_comb begin
      grant_o = '0;
      v_o     = 1'b0;
      data_o  = data_i[0];
      if (state_r == BUSY) begin
         grant_o[lock_r] = 1'b1;
         v_o             = v_i[lock_r];
         data_o          = data_i[lock_r];
      end else if (any_v) begin
         grant_o[sel] = 1'b1;
         v_o          = 1'b1;
         data_o       = data_i[sel];
      end
   end

   assign ready_and_o = grant_o & {num_in_p{ready_and_i}};
   assign xfer        = v_o & ready_and_i;
   assign hdr_len     = data_o[cord_width_p +: len_width_p];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r  <= IDLE;
         count_r  <= '0;
         lock_r   <= '0;
         rr_ptr_r <= '0;
      end else if (xfer) begin
         if (state_r == IDLE) begin
            rr_ptr_r <= next_ptr;
            if (hdr_len != '0) begin
               state_r <= BUSY;
               lock_r  <= sel;
               count_r <= hdr_len;
            end
         end else begin
            count_r <= count_r - len_width_p'(1);
            if (count_r == len_width_p'(1)) state_r <= IDLE;
         end
      end
   end

`ifdef BSG_CHIP_POD_WH_ARBITER_STATS_EN
   logic hdr_xfer;
   assign hdr_xfer = xfer && (state_r == IDLE);

   for (genvar k = 0; k < num_in_p; k++) begin : g_stat
      bsg_chip_pod_wh_pkt_counter #(.width_p(16)) cnt (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .inc_i   (hdr_xfer & grant_o[k]),
         .count_o (pkt_count_o[k])
      );
   end
`else
   assign pkt_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_chip_pod_wh_arbiter.sv
// Self-checking bench for bsg_chip_pod_wh_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a transaction-level reference model.
module tb_bsg_chip_pod_wh_arbiter;
   localparam int N  = 2;
   localparam int W  = 32;
   localparam int CW = 7;
   localparam int LW = 4;

   logic                  clk = 1'b0;
   logic                  reset_i;
   logic [N-1:0]          v_i;
   logic [N-1:0][W-1:0]   data_i;
   logic [N-1:0]          ready_and_o;
   logic                  v_o;
   logic [W-1:0]          data_o;
   logic                  ready_and_i;
   logic [N-1:0]          grant_o;
   logic [N-1:0][15:0]    pkt_count_o;

   bsg_chip_pod_wh_arbiter #(
      .num_in_p(N), .flit_width_p(W), .cord_width_p(CW), .len_width_p(LW)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .v_i         (v_i),
      .data_i      (data_i),
      .ready_and_o (ready_and_o),
      .v_o         (v_o),
      .data_o      (data_o),
      .ready_and_i (ready_and_i),
      .grant_o     (grant_o),
      .pkt_count_o (pkt_count_o)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model: which input owns the link, flits left, who has priority
   int m_busy, m_lock, m_rem, m_rr;
   int m_cnt[N];
   logic          e_v;
   logic [W-1:0]  e_data;
   logic [N-1:0]  e_grant, e_rdy;
   int            e_sel;

   typedef logic [W-1:0] flit_q_t[$];
   flit_q_t srcq[N];

   function automatic logic [W-1:0] mk_hdr(int len, int cord);
      logic [W-1:0] h;
      h          = $urandom;
      h[CW+:LW]  = LW'(len);
      h[CW-1:0]  = CW'(cord);
      return h;
   endfunction

   function automatic logic [15:0] exp_cnt(int k);
`ifdef BSG_CHIP_POD_WH_ARBITER_STATS_EN
      return 16'(m_cnt[k]);
`else
      return 16'(k * 0);
`endif
   endfunction

   task automatic model_eval();
      bit found;
      found   = 0;
      e_grant = '0;
      e_sel   = 0;
      e_v     = 1'b0;
      if (m_busy != 0) begin
         e_sel            = m_lock;
         e_grant[m_lock]  = 1'b1;
         e_v              = v_i[m_lock];
      end else begin
         for (int i = 0; i < N; i++) begin
            int j;
            j = (m_rr + i) % N;
            if (!found && v_i[j]) begin
               found      = 1;
               e_sel      = j;
               e_grant[j] = 1'b1;
               e_v        = 1'b1;
            end
         end
      end
      e_data = data_i[e_sel];
      e_rdy  = ready_and_i ? e_grant : '0;
   endtask

   task automatic model_clk();
      if (reset_i) begin
         m_busy = 0; m_lock = 0; m_rem = 0; m_rr = 0;
         for (int k = 0; k < N; k++) m_cnt[k] = 0;
         return;
      end
      if (e_v && ready_and_i) begin
         if (m_busy == 0) begin
            int len;
            len = int'(data_i[e_sel][CW+:LW]);
            if (m_cnt[e_sel] < 65535) m_cnt[e_sel]++;
            m_rr = (e_sel + 1) % N;
            if (len > 0) begin
               m_busy = 1; m_lock = e_sel; m_rem = len;
            end
         end else begin
            m_rem--;
            if (m_rem == 0) m_busy = 0;
         end
      end
   endtask

   task automatic tick();
      model_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_i     = 1'b1;
      v_i         = '0;
      ready_and_i = 1'b0;
      #4;
      model_eval();
      tick();
      reset_i = 1'b0;
      for (int k = 0; k < N; k++) srcq[k].delete();
   endtask

   task automatic test_reset();
      reset_i = 1'b1; v_i = '0; ready_and_i = 1'b1; data_i = '0;
      #4;
      model_eval();
      checks++;
      if ({v_o, grant_o, ready_and_o} !== '0) begin
         failures++;
         $display("FAIL reset_idle_outputs: got v=%b grant=%b rdy=%b want all 0", v_o, grant_o, ready_and_o);
      end
      checks++;
      if (pkt_count_o !== '0) begin
         failures++;
         $display("FAIL reset_pkt_count: got %h want 0", pkt_count_o);
      end
      tick();
      v_i = 2'b10; data_i[1] = mk_hdr(3, 9); data_i[0] = $urandom;
      #4;
      model_eval();
      checks++;
      if ({v_o, grant_o, ready_and_o} !== {1'b1, 2'b10, 2'b10} || data_o !== data_i[1]) begin
         failures++;
         $display("FAIL reset_comb_grant: got v=%b grant=%b rdy=%b data=%h want 1 10 10 %h",
                  v_o, grant_o, ready_and_o, data_o, data_i[1]);
      end
      tick();
      reset_i = 1'b0;
   endtask

   task automatic test_single_input();
      logic [W-1:0] f[3];
      do_reset();
      f[0] = mk_hdr(2, 5); f[1] = $urandom; f[2] = $urandom;
      ready_and_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         v_i       = (c < 3) ? 2'b10 : 2'b00;
         data_i[0] = $urandom;
         data_i[1] = (c < 3) ? f[c] : $urandom;
         #4;
         model_eval();
         checks++;
         if (c < 3) begin
            if (v_o !== 1'b1 || grant_o !== 2'b10 || data_o !== f[c]) begin
               failures++;
               $display("FAIL single_flit%0d: got v=%b grant=%b data=%h want 1 10 %h", c, v_o, grant_o, data_o, f[c]);
            end
         end else if (grant_o !== 2'b00 || v_o !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got v=%b grant=%b want 0 00", v_o, grant_o);
         end
         tick();
      end
   endtask

   task automatic test_alternate();
      logic [N-1:0][15:0] exp_pc;
      do_reset();
      ready_and_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         v_i       = 2'b11;
         data_i[0] = mk_hdr(0, 1);
         data_i[1] = mk_hdr(0, 2);
         #4;
         model_eval();
         checks++;
         if (grant_o !== ((c % 2) ? 2'b10 : 2'b01) || data_o !== data_i[c % 2]) begin
            failures++;
            $display("FAIL alternate_grant%0d: got grant=%b data=%h want %b %h",
                     c, grant_o, data_o, (c % 2) ? 2'b10 : 2'b01, data_i[c % 2]);
         end
         tick();
      end
      v_i = '0;
`ifdef BSG_CHIP_POD_WH_ARBITER_STATS_EN
      exp_pc = {16'd2, 16'd2};
`else
      exp_pc = '0;
`endif
      #4;
      model_eval();
      checks++;
      if (pkt_count_o !== exp_pc) begin
         failures++;
         $display("FAIL alternate_pkt_count: got %h want %h", pkt_count_o, exp_pc);
      end
      tick();
   endtask

   task automatic test_lock();
      logic [W-1:0] f[4];
      do_reset();
      f[0] = mk_hdr(3, 4);
      for (int i = 1; i < 4; i++) f[i] = $urandom;
      ready_and_i = 1'b1;
      data_i[1]   = mk_hdr(0, 3);
      for (int c = 0; c < 5; c++) begin
         v_i       = 2'b11;
         data_i[0] = (c < 4) ? f[c] : mk_hdr(0, 6);
         #4;
         model_eval();
         checks++;
         if (c < 4) begin
            if (grant_o !== 2'b01 || ready_and_o[1] !== 1'b0 || data_o !== f[c]) begin
               failures++;
               $display("FAIL lock_hold%0d: got grant=%b rdy=%b data=%h want 01 01 %h",
                        c, grant_o, ready_and_o, data_o, f[c]);
            end
         end else if (grant_o !== 2'b10 || ready_and_o !== 2'b10) begin
            failures++;
            $display("FAIL lock_release: got grant=%b rdy=%b want 10 10", grant_o, ready_and_o);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      logic [W-1:0] f[4];
      logic [W-1:0] got[$];
      bit rdy_pat[8] = '{1, 0, 0, 1, 1, 1, 1, 1};
      bit v_pat[8]   = '{1, 1, 1, 1, 0, 1, 1, 0};
      int idx;
      do_reset();
      f[0] = mk_hdr(3, 8);
      for (int i = 1; i < 4; i++) f[i] = $urandom;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         v_i         = {1'b0, (v_pat[c] && idx < 4)};
         data_i[0]   = (idx < 4) ? f[idx] : '0;
         data_i[1]   = $urandom;
         ready_and_i = rdy_pat[c];
         #4;
         model_eval();
         checks++;
         if (v_o !== e_v || grant_o !== e_grant || data_o !== e_data) begin
            failures++;
            $display("FAIL stall_cycle%0d: got v=%b grant=%b data=%h want %b %b %h",
                     c, v_o, grant_o, data_o, e_v, e_grant, e_data);
         end
         if (v_o && ready_and_i) got.push_back(data_o);
         if (v_i[0] && e_rdy[0]) idx++;
         tick();
      end
      checks++;
      if (got.size() != 4) begin
         failures++;
         $display("FAIL stall_flit_count: got %0d want 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== f[i]) begin
               failures++;
               $display("FAIL stall_flit%0d: got %h want %h", i, got[i], f[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] f[5];
      do_reset();
      f[0] = mk_hdr(4, 2);
      for (int i = 1; i < 5; i++) f[i] = $urandom;
      ready_and_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         v_i = 2'b01; data_i[0] = f[c]; data_i[1] = $urandom;
         #4;
         model_eval();
         checks++;
         if (grant_o !== 2'b01 || data_o !== f[c]) begin
            failures++;
            $display("FAIL rstmid_flit%0d: got grant=%b data=%h want 01 %h", c, grant_o, data_o, f[c]);
         end
         tick();
      end
      reset_i = 1'b1; data_i[0] = f[2];
      #4;
      model_eval();
      tick();
      reset_i = 1'b0;
      v_i = 2'b00; ready_and_i = 1'b0;
      #4;
      model_eval();
      checks++;
      if (grant_o !== 2'b00 || v_o !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_idle: got grant=%b v=%b want 00 0", grant_o, v_o);
      end
      tick();
      v_i = 2'b11; ready_and_i = 1'b1;
      data_i[0] = mk_hdr(0, 1); data_i[1] = mk_hdr(0, 2);
      #4;
      model_eval();
      checks++;
      if (grant_o !== 2'b01 || v_o !== 1'b1 || data_o !== data_i[0]) begin
         failures++;
         $display("FAIL rstmid_rr_zero: got grant=%b v=%b data=%h want 01 1 %h", grant_o, v_o, data_o, data_i[0]);
      end
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0][15:0] exp_pc;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (srcq[k].size() == 0) begin
               int len;
               len = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
               srcq[k].push_back(mk_hdr(len, k));
               for (int b = 0; b < len; b++) srcq[k].push_back($urandom);
            end
            v_i[k]    = ($urandom_range(0, 3) != 0);
            data_i[k] = srcq[k][0];
         end
         ready_and_i = ($urandom_range(0, 3) != 0);
         reset_i     = ($urandom_range(0, 299) == 0);
         #4;
         model_eval();
         for (int k = 0; k < N; k++) exp_pc[k] = exp_cnt(k);
         checks++;
         if (v_o !== e_v || grant_o !== e_grant) begin
            failures++;
            $display("FAIL rand_ctl@%0d: got v=%b grant=%b want %b %b", cyc, v_o, grant_o, e_v, e_grant);
         end
         checks++;
         if (ready_and_o !== e_rdy) begin
            failures++;
            $display("FAIL rand_ready@%0d: got %b want %b", cyc, ready_and_o, e_rdy);
         end
         checks++;
         if (data_o !== e_data) begin
            failures++;
            $display("FAIL rand_data@%0d: got %h want %h", cyc, data_o, e_data);
         end
         checks++;
         if (pkt_count_o !== exp_pc) begin
            failures++;
            $display("FAIL rand_pkt_count@%0d: got %h want %h", cyc, pkt_count_o, exp_pc);
         end
         if (reset_i) begin
            for (int k = 0; k < N; k++) srcq[k].delete();
         end else begin
            for (int k = 0; k < N; k++)
               if (v_i[k] && e_rdy[k]) void'(srcq[k].pop_front());
         end
         tick();
      end
      reset_i = 1'b0;
   endtask

`ifdef BSG_CHIP_POD_WH_ARBITER_STATS_EN
   task automatic test_saturation();
      do_reset();
      v_i = 2'b01; ready_and_i = 1'b1;
      data_i[0] = mk_hdr(0, 1); data_i[1] = $urandom;
      repeat (65534) @(posedge clk);
      #1;
      checks++;
      if (pkt_count_o[0] !== 16'hFFFE) begin
         failures++;
         $display("FAIL sat_pre: got %h want fffe", pkt_count_o[0]);
      end
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (pkt_count_o[0] !== 16'hFFFF || pkt_count_o[1] !== 16'h0) begin
         failures++;
         $display("FAIL sat_hold: got %h %h want ffff 0000", pkt_count_o[0], pkt_count_o[1]);
      end
      do_reset();
   endtask
`endif

   initial begin
      reset_i = 1'b1; v_i = '0; data_i = '0; ready_and_i = 1'b0;
      m_busy = 0; m_lock = 0; m_rem = 0; m_rr = 0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_single_input();
      test_alternate();
      test_lock();
      test_stall();
      test_reset_mid();
      test_random();
`ifdef BSG_CHIP_POD_WH_ARBITER_STATS_EN
      test_saturation();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
